// File: rtl/sobel_sat_out.sv
// Sobel output stage. It saturates or thresholds each gradient sum to
// DATAWIDTH bits, buffers the result in a small FIFO, and streams it out on
// an AXI-Stream master with frame accounting and dropped-beat detection.
module sobel_sat_out #(
  parameter int PIXEL     = 3,
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         ARESETN,
  input  logic [2*DATAWIDTH*PIXEL-1:0] packed_sum,
  input  logic                         i_strobe,
  input  logic                         in_tlast,
  output logic                         o_busy,
  input  logic                         i_thresh_en,
  input  logic [DATAWIDTH-1:0]         i_threshold,
  output logic [DATAWIDTH*PIXEL-1:0]   m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         o_frame_done,
  output logic [15:0]                  o_frame_beats,
  output logic                         o_overflow
);

  localparam int OW = DATAWIDTH * PIXEL;
  localparam int SW = 2 * DATAWIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BUSY_C  = CW'(DEPTH - 1);

  // Clamp one sum to the output range, then optionally binarise it.
  function automatic logic [DATAWIDTH-1:0] process_pixel(
    input logic [SW-1:0]        sum,
    input logic                 thresh_en,
    input logic [DATAWIDTH-1:0] threshold
  );
    logic [DATAWIDTH-1:0] sat;
    sat = (|sum[SW-1:DATAWIDTH]) ? '1 : sum[DATAWIDTH-1:0];
    if (thresh_en) return (sat >= threshold) ? '1 : '0;
    return sat;
  endfunction

  // Stage-1 register
  logic          s1_valid;
  logic [OW-1:0] s1_data;
  logic          s1_last;

  // FIFO storage: {tlast, tdata} per entry
  logic [OW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  logic [15:0]   frame_cnt;
  logic [15:0]   frame_cnt_inc;

  logic [OW-1:0] pix_out;
  logic [CW-1:0] occupancy;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_full;

  // Per-pixel saturate/threshold of the incoming beat.
  always_comb begin
    // NOTE: assign a default before the loop so no bit is left holding its old value (latch).
    pix_out = '0;
    for (int k = 0; k < PIXEL; k++) begin
      pix_out[DATAWIDTH*k +: DATAWIDTH] =
        process_pixel(packed_sum[SW*k +: SW], i_thresh_en, i_threshold);
    end
  end

  assign occupancy     = fifo_count + CW'(s1_valid);
  assign fifo_full     = (fifo_count == DEPTH_C);
  assign accept        = i_strobe && (occupancy < DEPTH_C);
  assign push          = s1_valid && !fifo_full;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign frame_cnt_inc = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;

  assign m_axis_tvalid = (fifo_count != '0);
  assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr];

  // Stage 1: capture the processed beat; empty once it moves into the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!ARESETN) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= pix_out;
      s1_last  <= in_tlast;
    end else if (push) begin
      s1_valid <= 1'b0;
    end
  end

  // Output FIFO: write from stage 1, read on AXIS handshake.
  always_ff @(posedge clk) begin
    if (!ARESETN) begin
      // NOTE: the entries are cleared too, so tdata/tlast read zero after reset and no stale beat survives.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {s1_last, s1_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Back-pressure lags occupancy by one cycle; the free slot absorbs that lag.
  always_ff @(posedge clk) begin
    if (!ARESETN) begin
      o_busy     <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      o_busy     <= (occupancy >= BUSY_C);
      o_overflow <= o_overflow | (i_strobe & ~accept);
    end
  end

  // Frame accounting on output handshakes; the beat counter saturates.
  always_ff @(posedge clk) begin
    if (!ARESETN) begin
      frame_cnt     <= '0;
      o_frame_beats <= '0;
      o_frame_done  <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (pop) begin
        if (m_axis_tlast) begin
          o_frame_beats <= frame_cnt_inc;
          o_frame_done  <= 1'b1;
          frame_cnt     <= '0;
        end else begin
          frame_cnt <= frame_cnt_inc;
        end
      end
    end
  end

endmodule
